// File: rtl/ro_worker_core.sv
// ro_worker_core: byte-serial loaded counter core with four counting modes; the
// result is read back byte-by-byte on the same asynchronous shift strobe.
module ro_worker_core #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 3
) (
    input  logic       internal_clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       shift,
    input  logic       stop,
    input  logic [1:0] mode,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       aborted
);
    localparam int NBYTES = WIDTH / 8;
    localparam int BCW = $clog2(2 * NBYTES);
    localparam logic [BCW-1:0] LAST = BCW'(2 * NBYTES - 1);

    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] shift_sync_q, stop_sync_q;
    logic                   shift_hist_q, stop_hist_q;
    logic [2*WIDTH-1:0]     ops_q, ops_d;
    logic [WIDTH-1:0]       acc_q, cnt_q, opa_d, opb, acc_rot, acc_step;
    logic [BCW-1:0]         byte_cnt_q;
    logic [1:0]             mode_q;
    logic                   overflow_q, aborted_q;
    logic                   shift_rise, stop_rise, down, wrap, hit, halt;

    assign shift_rise = shift_sync_q[SYNC_STAGES-1] & ~shift_hist_q;
    assign stop_rise  = stop_sync_q[SYNC_STAGES-1] & ~stop_hist_q;
    assign ops_d      = (ops_q << 8) | {{(2*WIDTH-8){1'b0}}, din};
    assign opa_d      = ops_d[2*WIDTH-1:WIDTH];
    assign opb        = ops_q[WIDTH-1:0];
    assign acc_rot    = (acc_q << 8) | (acc_q >> (WIDTH - 8));
    assign down       = mode_q == 2'd2;
    assign acc_step   = down ? acc_q - WIDTH'(1) : acc_q + WIDTH'(1);
    assign wrap       = down ? acc_q == '0 : acc_q == '1;
    assign hit        = mode_q != 2'd1 && cnt_q == opb;
    assign halt       = hit || (mode_q[0] && stop_rise);

    assign dout     = acc_q[WIDTH-1 -: 8];
    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign overflow = overflow_q;
    assign aborted  = aborted_q;

    always_ff @(posedge internal_clock) begin
        if (reset) begin
            state_q      <= LOAD;
            // Chains idle high: a strobe held across reset must fall and rise again to act.
            shift_sync_q <= '1;
            stop_sync_q  <= '1;
            shift_hist_q <= 1'b1;
            stop_hist_q  <= 1'b1;
            ops_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            byte_cnt_q   <= '0;
            mode_q       <= '0;
            overflow_q   <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            shift_sync_q <= {shift_sync_q[SYNC_STAGES-2:0], shift};
            stop_sync_q  <= {stop_sync_q[SYNC_STAGES-2:0], stop};
            shift_hist_q <= shift_sync_q[SYNC_STAGES-1];
            stop_hist_q  <= stop_sync_q[SYNC_STAGES-1];
            case (state_q)
                RUN: begin
                    cnt_q <= cnt_q + WIDTH'(1);
                    acc_q <= acc_step;
                    if (wrap) overflow_q <= 1'b1;
                    if (halt) begin
                        state_q   <= DONE;
                        aborted_q <= mode_q == 2'd3 && !hit;
                    end
                end
                default: if (shift_rise) begin
                    ops_q <= ops_d;
                    if (byte_cnt_q == LAST) begin
                        acc_q      <= mode == 2'd1 ? opa_d + ops_d[WIDTH-1:0] : opa_d;
                        byte_cnt_q <= '0;
                        cnt_q      <= '0;
                        overflow_q <= 1'b0;
                        aborted_q  <= 1'b0;
                        mode_q     <= mode;
                        state_q    <= RUN;
                    end else begin
                        acc_q      <= acc_rot;
                        byte_cnt_q <= byte_cnt_q + BCW'(1);
                        state_q    <= LOAD;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ro_worker_core.sv
// tb_ro_worker_core: randomized runs scored against an arithmetic reference model;
// a monitor pops expected results when done rises and during the following readout.
module tb_ro_worker_core;
    localparam int W = 16;
    localparam int SYNC = 3;

    typedef struct {
        logic [W-1:0] acc;
        logic         ovf;
        logic         ab;
        int           n;
    } exp_t;

    logic       clk = 0, reset = 1, shift = 0, stop = 0;
    logic [7:0] din = 0, dout;
    logic [1:0] mode = 0;
    logic       busy, done, overflow, aborted;
    int         checks = 0, errors = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    ro_worker_core #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .internal_clock(clk), .reset(reset), .din(din), .shift(shift), .stop(stop),
        .mode(mode), .dout(dout), .busy(busy), .done(done), .overflow(overflow),
        .aborted(aborted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run length n: target needs opb+1 updates; a stop raised after RUN-entry edge+j
    // terminates on update j+1+SYNC. Result is plain modular arithmetic on n.
    function automatic exp_t model(input logic [W-1:0] opa, input logic [W-1:0] opb,
                                   input logic [1:0] md, input int stop_j);
        exp_t   e;
        longint modulus, start, n, n_tgt, n_stop;
        modulus = longint'(1) << W;
        n_tgt   = longint'(opb) + 1;
        n_stop  = stop_j < 0 ? (longint'(1) << 40) : longint'(stop_j + 1 + SYNC);
        start   = md == 2'd1 ? (longint'(opa) + longint'(opb)) % modulus : longint'(opa);
        n       = md == 2'd1 ? n_stop : (md == 2'd3 && n_stop < n_tgt) ? n_stop : n_tgt;
        e.ab    = md == 2'd3 && n_stop < n_tgt;
        e.acc   = W'(md == 2'd2 ? start - n : start + n);
        e.ovf   = md == 2'd2 ? n > start : start + n >= modulus;
        e.n     = int'(n);
        return e;
    endfunction

    logic prev_done = 0;
    bit   have_cur = 0;
    int   busy_len = 0;
    exp_t cur;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            busy_len  = 0;
            have_cur  = 0;
            prev_done = 0;
        end else begin
            if (busy) busy_len++;
            if (done && !prev_done) begin
                chk("done_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    cur      = sb.pop_front();
                    have_cur = 1;
                    chk("run_len", busy_len, cur.n);
                    chk("dout_hi", dout, cur.acc[W-1 -: 8]);
                    chk("overflow", overflow, cur.ovf);
                    chk("aborted", aborted, cur.ab);
                end
                busy_len = 0;
            end
            if (!done && prev_done && have_cur) begin
                chk("dout_lo", dout, cur.acc[7:0]);
                have_cur = 0;
            end
            prev_done = done;
        end
    end

    task automatic pulse(input logic [7:0] b);
        @(negedge clk);
        din   = b;
        shift = 1;
        stop  = 1'($urandom);
        repeat (SYNC + 2) @(negedge clk);
        shift = 0;
        stop  = 0;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    task automatic run(input logic [W-1:0] opa, input logic [W-1:0] opb, input logic [1:0] md,
                       input int stop_j, input bit tg, input int rst_k);
        logic [2*W-1:0] ops;
        ops = {opa, opb};
        if (rst_k < 0) sb.push_back(model(opa, opb, md, stop_j));
        mode = md;
        for (int i = 2 * W / 8 - 1; i > 0; i--) pulse(ops[8*i +: 8]);
        @(negedge clk);
        din   = ops[7:0];
        shift = 1;
        stop  = 0;
        repeat (SYNC + 1) @(negedge clk);
        for (int k = 0; k <= 1000; k++) begin
            if (done) break;
            if (k == rst_k) begin
                reset = 1;
                @(negedge clk);
                chk("rst_dout", dout, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_overflow", overflow, 0);
                chk("rst_aborted", aborted, 0);
                reset = 0;
                break;
            end
            if (k == 1000) begin
                checks++;
                errors++;
                $display("FAIL run_timeout: done still %0d after %0d cycles", done, k);
                if (sb.size() != 0) void'(sb.pop_back());
                break;
            end
            if (k == stop_j) stop = 1;
            if (k == stop_j + SYNC + 3) stop = 0;
            shift = k < 2 || (tg && k >= 10 && k < 60 && (k / 10) % 2 == 1);
            if (k == 1) mode = 2'($urandom);
            @(negedge clk);
        end
        shift = 0;
        stop  = 0;
        repeat (SYNC + 2) @(negedge clk);
    endtask

    initial begin
        logic [1:0]   md;
        logic [W-1:0] a, b;
        int           sj;
        reset = 1;
        shift = 1;
        repeat (2) begin
            @(negedge clk);
            stop = ~stop;
        end
        @(negedge clk);
        reset = 0;
        stop  = 0;
        @(negedge clk);
        chk("init_dout", dout, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_overflow", overflow, 0);
        chk("init_aborted", aborted, 0);
        repeat (SYNC + 3) @(negedge clk);
        chk("held_shift_busy", busy, 0);
        shift = 0;
        repeat (SYNC + 2) @(negedge clk);

        run(16'h1234, 16'h0010, 2'd0, -1, 0, -1);
        run(16'hFFF0, 16'h000F, 2'd1, 6, 0, -1);
        run(16'h0005, 16'h0007, 2'd2, -1, 0, -1);
        run(16'h0000, 16'h1000, 2'd3, 16, 0, -1);
        run(16'h0000, 16'h0003, 2'd3, 0, 0, -1);
        run(16'h0000, 16'h0100, 2'd0, -1, 1, -1);
        run(16'h0000, 16'h0100, 2'd0, -1, 1, 100);

        for (int r = 0; r < 12; r++) begin
            md = 2'($urandom);
            a  = ($urandom_range(0, 2) == 0) ? W'(16'hFFF0 + $urandom_range(0, 15)) : W'($urandom);
            b  = W'($urandom_range(0, 40));
            sj = md == 2'd1 ? int'($urandom_range(0, 30)) :
                 (md == 2'd3 && $urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 45));
            run(a, b, md, sj, 0, -1);
        end
        pulse(8'h00);
        pulse(8'h00);
        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
